// File: rtl/avalon_pkg.sv
// Shared Avalon-MM definitions: bus widths, read-response record and the
// byte-lane merge used for masked writes.
package avalon_pkg;
  localparam int AV_DATA_W = 32;
  localparam int AV_BE_W   = 4;

  typedef struct packed {
    logic                 vld;
    logic [AV_DATA_W-1:0] data;
  } av_rsp_t;

  function automatic logic [AV_DATA_W-1:0] av_be_merge(
    input logic [AV_DATA_W-1:0] old_w,
    input logic [AV_DATA_W-1:0] new_w,
    input logic [AV_BE_W-1:0]   be
  );
    logic [AV_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < AV_BE_W; i++)
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/avalon_bank_responder_if.sv
// Avalon-MM slave-side bus bundle between an accelerator master and the bank.
interface avalon_bank_responder_if;
  import avalon_pkg::*;
  logic                 slave_waitrequest;
  logic [31:0]          slave_address;
  logic                 slave_read;
  logic                 slave_write;
  logic [AV_DATA_W-1:0] slave_writedata;
  logic [AV_BE_W-1:0]   slave_byteenable;
  logic [AV_DATA_W-1:0] slave_readdata;
  logic                 slave_readdatavalid;

  modport master (
    input  slave_waitrequest, slave_readdata, slave_readdatavalid,
    output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable
  );
  modport slave (
    output slave_waitrequest, slave_readdata, slave_readdatavalid,
    input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable
  );
endinterface

// File: rtl/avalon_rd_pipe.sv
// Fixed-latency read-response delay line; synchronous flush drops all in-flight reads.
module avalon_rd_pipe
  import avalon_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  av_rsp_t rsp_i,
  output av_rsp_t rsp_o
);
  av_rsp_t pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= rsp_i;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_o = pipe_q[LATENCY-1];
endmodule

// File: rtl/avalon_bank_responder.sv
// Avalon-MM slave memory bank with pipelined fixed-latency reads, byte-enabled
// writes, a read-pending limit and deterministic periodic stall cycles.
module avalon_bank_responder
  import avalon_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 2,
  parameter int MAX_PENDING  = 4,
  parameter int WAIT_EVERY   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  avalon_bank_responder_if.slave  s
);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam int CNT_W  = (WAIT_EVERY > 0) ? $clog2(WAIT_EVERY + 1) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic [AV_DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    word;
  logic                 accept, rd_acc, wr_acc;
  logic [PEND_W-1:0]    pend_q, pend_d;
  logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                 stall_q, stall_d;
  av_rsp_t              rsp_in, rsp_out;
  logic                 unused_addr;

  // Byte-offset and high address bits alias onto the same word.
  assign word        = s.slave_address[ADDR_W+1:2];
  assign unused_addr = ^{s.slave_address[31:ADDR_W+2], s.slave_address[1:0]};

  assign s.slave_waitrequest = (pend_q == PEND_W'(MAX_PENDING)) | stall_q;
  assign accept = (s.slave_read | s.slave_write) & ~s.slave_waitrequest & rst_n;
  assign wr_acc = accept & s.slave_write;
  assign rd_acc = accept & s.slave_read & ~s.slave_write;

  assign rsp_in.vld  = rd_acc;
  assign rsp_in.data = rd_acc ? mem_q[word] : '0;

  always_comb begin
    pend_d    = pend_q;
    acc_cnt_d = acc_cnt_q;
    stall_d   = 1'b0;
    case ({rd_acc, rsp_out.vld})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: ;
    endcase
    if (WAIT_EVERY > 0 && accept) begin
      if (acc_cnt_q == CNT_W'(WAIT_EVERY - 1)) begin
        acc_cnt_d = '0;
        stall_d   = 1'b1;
      end else begin
        acc_cnt_d = acc_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q    <= '0;
      acc_cnt_q <= '0;
      stall_q   <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      acc_cnt_q <= acc_cnt_d;
      stall_q   <= stall_d;
    end
  end

  // Memory is intentionally not reset so contents survive a bank reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[word] <= av_be_merge(mem_q[word], s.slave_writedata, s.slave_byteenable);
  end

  avalon_rd_pipe #(.LATENCY(READ_LATENCY)) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .rsp_i (rsp_in),
    .rsp_o (rsp_out)
  );

  assign s.slave_readdatavalid = rsp_out.vld;
  assign s.slave_readdata      = rsp_out.data;
endmodule

// File: tb/tb_avalon_bank_responder.sv
// Bench for three bank configurations (default, MAX_PENDING=1/READ_LATENCY=3,
// WAIT_EVERY=2) checked cycle by cycle against a table-driven reference model.
module tb_avalon_bank_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_bank_responder_if ifa ();
  avalon_bank_responder_if ifb ();
  avalon_bank_responder_if ifc ();

  avalon_bank_responder #(.ADDR_W(10), .READ_LATENCY(2), .MAX_PENDING(4), .WAIT_EVERY(0))
    dut_a (.clk(clk), .rst_n(rst_n), .s(ifa));
  avalon_bank_responder #(.ADDR_W(10), .READ_LATENCY(3), .MAX_PENDING(1), .WAIT_EVERY(0))
    dut_b (.clk(clk), .rst_n(rst_n), .s(ifb));
  avalon_bank_responder #(.ADDR_W(10), .READ_LATENCY(2), .MAX_PENDING(4), .WAIT_EVERY(2))
    dut_c (.clk(clk), .rst_n(rst_n), .s(ifc));

  logic        c_rd [3];
  logic        c_wr [3];
  logic [31:0] c_addr [3];
  logic [31:0] c_wd [3];
  logic [3:0]  c_be [3];
  logic        wreq [3];
  logic        rdv [3];
  logic [31:0] rdat [3];

  assign ifa.slave_read = c_rd[0]; assign ifa.slave_write = c_wr[0];
  assign ifa.slave_address = c_addr[0]; assign ifa.slave_writedata = c_wd[0];
  assign ifa.slave_byteenable = c_be[0];
  assign ifb.slave_read = c_rd[1]; assign ifb.slave_write = c_wr[1];
  assign ifb.slave_address = c_addr[1]; assign ifb.slave_writedata = c_wd[1];
  assign ifb.slave_byteenable = c_be[1];
  assign ifc.slave_read = c_rd[2]; assign ifc.slave_write = c_wr[2];
  assign ifc.slave_address = c_addr[2]; assign ifc.slave_writedata = c_wd[2];
  assign ifc.slave_byteenable = c_be[2];
  assign wreq[0] = ifa.slave_waitrequest; assign rdv[0] = ifa.slave_readdatavalid;
  assign rdat[0] = ifa.slave_readdata;
  assign wreq[1] = ifb.slave_waitrequest; assign rdv[1] = ifb.slave_readdatavalid;
  assign rdat[1] = ifb.slave_readdata;
  assign wreq[2] = ifc.slave_waitrequest; assign rdv[2] = ifc.slave_readdatavalid;
  assign rdat[2] = ifc.slave_readdata;

  // Reference model: per-instance memory image and a per-cycle table of expected responses.
  int          LAT [3] = '{2, 3, 2};
  int          MP  [3] = '{4, 1, 4};
  int          WE  [3] = '{0, 0, 2};
  bit [31:0]   mem_m [3][1024];
  bit          exp_vld [3][2048];
  bit [31:0]   exp_dat [3][2048];
  int          acc_cnt [3];
  int          stall_cyc [3];
  bit          accd [3];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc=%0d observed=%h expected=%h", tag, k, cyc, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic logic [31:0] rnd_addr(input int w);
    return ($urandom & 32'hFFFF_F003) | (32'(w) << 2);
  endfunction

  task automatic cmd(input int k, input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    c_rd[k] = rd; c_wr[k] = wr; c_addr[k] = a; c_wd[k] = d; c_be[k] = be;
  endtask

  task automatic clr(input int k);
    cmd(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // One clock: check waitrequest, apply accepted commands to the model, advance, check responses.
  task automatic step();
    for (int k = 0; k < 3; k++) begin
      int pend;
      bit ew;
      int w;
      pend = 0;
      for (int t = cyc; t < cyc + LAT[k]; t++) pend += int'(exp_vld[k][t]);
      ew = (pend >= MP[k]) || (stall_cyc[k] == cyc);
      chk("waitrequest", k, 32'(wreq[k]), 32'(ew));
      accd[k] = rst_n && (c_rd[k] || c_wr[k]) && !ew;
      if (accd[k]) begin
        w = word_of(c_addr[k]);
        if (c_wr[k]) begin
          for (int b = 0; b < 4; b++)
            if (c_be[k][b]) mem_m[k][w][8*b +: 8] = c_wd[k][8*b +: 8];
        end else begin
          exp_vld[k][cyc + LAT[k]] = 1'b1;
          exp_dat[k][cyc + LAT[k]] = mem_m[k][w];
        end
        if (WE[k] > 0) begin
          acc_cnt[k]++;
          if (acc_cnt[k] == WE[k]) begin
            acc_cnt[k] = 0;
            stall_cyc[k] = cyc + 1;
          end
        end
      end
      if (!rst_n) begin
        acc_cnt[k] = 0;
        stall_cyc[k] = -1;
        for (int t = cyc + 1; t < cyc + 10; t++) exp_vld[k][t] = 1'b0;
      end
    end
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      chk("readdatavalid", k, 32'(rdv[k]), 32'(exp_vld[k][cyc]));
      chk("readdata", k, rdat[k], exp_vld[k][cyc] ? exp_dat[k][cyc] : 32'h0);
    end
  endtask

  task automatic do_op(input int k, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    cmd(k, rd, wr, a, d, be);
    step();
    clr(k);
  endtask

  initial begin
    int pulses, first_p, last_p, hi, i, n, a1, a2;
    bit [1:0] op;
    logic [5:0] pat;
    for (int k = 0; k < 3; k++) begin
      clr(k);
      acc_cnt[k] = 0;
      stall_cyc[k] = -1;
    end
    repeat (2) @(posedge clk);
    #1;
    step();
    rst_n = 1'b1;
    step();

    // Full write then read back with fixed latency.
    do_op(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_op(0, 1, 0, 32'h10, 32'h0, 4'h0);
    step();
    chk("deadbeef_vld", 0, 32'(rdv[0]), 32'h1);
    chk("deadbeef_dat", 0, rdat[0], 32'hDEADBEEF);

    // Byte-masked overwrite.
    do_op(0, 0, 1, 32'h20, 32'h11223344, 4'hF);
    do_op(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
    do_op(0, 1, 0, 32'h20, 32'h0, 4'h0);
    step();
    chk("merge_dat", 0, rdat[0], 32'h11BB33DD);

    // Four back-to-back reads give four consecutive pulses.
    for (int j = 0; j < 4; j++) do_op(0, 0, 1, 32'(j*4), 32'hA000_0000 + 32'(j), 4'hF);
    pulses = 0; first_p = -1; last_p = -1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) cmd(0, 1, 0, 32'(j*4), 32'h0, 4'h0); else clr(0);
      step();
      if (rdv[0] === 1'b1) begin
        pulses++;
        if (first_p < 0) first_p = cyc;
        last_p = cyc;
      end
    end
    chk("b2b_pulses", 0, 32'(pulses), 32'd4);
    chk("b2b_span", 0, 32'(last_p - first_p), 32'd3);

    // Reset with two reads in flight; a write during reset is ignored.
    cmd(0, 1, 0, 32'h10, 32'h0, 4'h0); step();
    cmd(0, 1, 0, 32'h20, 32'h0, 4'h0); step();
    rst_n = 1'b0;
    cmd(0, 0, 1, 32'h10, 32'h0BADF00D, 4'hF); step();
    rst_n = 1'b1;
    clr(0);
    pulses = 0;
    for (int j = 0; j < 4; j++) begin
      step();
      if (rdv[0] !== 1'b0) pulses++;
    end
    chk("rst_flush", 0, 32'(pulses), 32'd0);
    do_op(0, 1, 0, 32'hFFFF_F010, 32'h0, 4'h0);
    step();
    chk("rst_retain", 0, rdat[0], 32'hDEADBEEF);

    // Randomized traffic on the default bank with address aliasing.
    for (int w = 0; w < 16; w++) do_op(0, 0, 1, rnd_addr(w), $urandom, 4'hF);
    for (int j = 0; j < 200; j++) begin
      op = 2'($urandom_range(0, 3));
      cmd(0, op[0], op[1], rnd_addr($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    clr(0);
    repeat (4) step();

    // MAX_PENDING=1, READ_LATENCY=3: held reads are spaced by three wait cycles.
    do_op(1, 0, 1, 32'h0, 32'hB0B0_0000, 4'hF);
    do_op(1, 0, 1, 32'h4, 32'hB1B1_1111, 4'hF);
    cmd(1, 1, 0, 32'h0, 32'h0, 4'h0);
    hi = 0; a1 = -1; a2 = -1;
    for (int j = 0; j < 20 && a2 < 0; j++) begin
      if (wreq[1] === 1'b1) hi++;
      step();
      if (accd[1]) begin
        if (a1 < 0) begin
          a1 = cyc - 1;
          cmd(1, 1, 0, 32'h4, 32'h0, 4'h0);
        end else a2 = cyc - 1;
      end
    end
    clr(1);
    chk("b_accepts_seen", 1, 32'(a2 >= 0), 32'h1);
    chk("b_gap", 1, 32'(a2 - a1), 32'd4);
    chk("b_wait_hi", 1, 32'(hi), 32'd3);
    repeat (4) step();
    for (int j = 0; j < 60; j++) begin
      op = 2'($urandom_range(0, 2));
      cmd(1, op == 2'd1, op == 2'd2, rnd_addr($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
      step();
    end
    clr(1);
    repeat (5) step();

    // WAIT_EVERY=2: four held writes, then held reads back.
    i = 0; n = 0; pat = '0;
    cmd(2, 0, 1, 32'h0, 32'hC000_0000, 4'hF);
    for (int j = 0; j < 20 && i < 4; j++) begin
      pat = {pat[4:0], wreq[2]};
      n++;
      step();
      if (accd[2]) begin
        i++;
        cmd(2, 0, 1, 32'(i*4), 32'hC000_0000 + 32'(i), 4'hF);
      end
    end
    clr(2);
    pat = {pat[4:0], wreq[2]};
    n++;
    chk("c_cycles", 2, 32'(n), 32'd6);
    chk("c_wait_pattern", 2, 32'(pat), 32'b001001);
    i = 0;
    cmd(2, 1, 0, 32'h0, 32'h0, 4'h0);
    for (int j = 0; j < 20 && i < 4; j++) begin
      step();
      if (accd[2]) begin
        i++;
        cmd(2, 1, 0, 32'(i*4), 32'h0, 4'h0);
      end
    end
    clr(2);
    chk("c_reads_done", 2, 32'(i), 32'd4);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
